// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - oversampled Philips I2S receiver producing parallel stereo samples
module i2s_rx_deser #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  bclk_in,
    input  logic                  lrck_in,
    input  logic                  sdata_in,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  frame_err
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

    localparam logic [1:0] ST_WAIT_EDGE = 2'd0;
    localparam logic [1:0] ST_CAP_LEFT  = 2'd1;
    localparam logic [1:0] ST_CAP_RIGHT = 2'd2;

    logic                  r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic                  r_lr_s1, r_lr_s2;
    logic                  r_d_s1, r_d_s2;
    logic                  r_lr_prev;
    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic [DATA_WIDTH-1:0] r_left_data;
    logic [DATA_WIDTH-1:0] r_right_data;
    logic                  r_sample_valid;
    logic                  r_frame_err;

    logic                  w_rise;
    logic                  w_boundary;
    logic                  w_take;
    logic [CW-1:0]         w_cnt_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [CW-1:0]         w_pad;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_short;

    // Rise of the bit clock seen in the system domain; lr/d come from the same stage.
    assign w_rise     = r_bclk_s2 & ~r_bclk_s3;
    assign w_boundary = w_rise & (r_lr_s2 != r_lr_prev);

    // Bits past DATA_WIDTH are dropped; a finished word is left-justified (zero pad at LSB).
    assign w_take       = (r_cnt < FULL_CNT);
    assign w_cnt_next   = w_take ? (r_cnt + CW'(1)) : r_cnt;
    assign w_shift_next = w_take ? ((r_shift << 1) | DATA_WIDTH'(r_d_s2)) : r_shift;
    assign w_pad        = FULL_CNT - w_cnt_next;
    assign w_word       = w_shift_next << w_pad;
    assign w_short      = (w_cnt_next < FULL_CNT);

    assign left_data    = r_left_data;
    assign right_data   = r_right_data;
    assign sample_valid = r_sample_valid;
    assign frame_err    = r_frame_err;

    // Two-flop synchronizers for all three pins plus a third bclk stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_s3 <= 1'b0;
            r_lr_s1   <= 1'b0;
            r_lr_s2   <= 1'b0;
            r_d_s1    <= 1'b0;
            r_d_s2    <= 1'b0;
            r_lr_prev <= 1'b0;
        end else begin
            r_bclk_s1 <= bclk_in;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_s3 <= r_bclk_s2;
            r_lr_s1   <= lrck_in;
            r_lr_s2   <= r_lr_s1;
            r_d_s1    <= sdata_in;
            r_d_s2    <= r_d_s1;
            if (w_rise) begin
                r_lr_prev <= r_lr_s2;
            end
        end
    end

    // Word capture, channel sequencing and stereo output update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_WAIT_EDGE;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_left_hold    <= '0;
            r_left_data    <= '0;
            r_right_data   <= '0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (!en) begin
                r_state     <= ST_WAIT_EDGE;
                r_cnt       <= '0;
                r_shift     <= '0;
                r_frame_err <= 1'b0;
            end else if (w_rise) begin
                case (r_state)
                    ST_WAIT_EDGE: begin
                        // Only a fresh left boundary gives a frame we can trust.
                        if (w_boundary && !r_lr_s2) begin
                            r_state <= ST_CAP_LEFT;
                            r_cnt   <= '0;
                            r_shift <= '0;
                        end
                    end
                    ST_CAP_LEFT: begin
                        if (w_boundary) begin
                            r_left_hold <= w_word;
                            r_cnt       <= '0;
                            r_shift     <= '0;
                            r_state     <= ST_CAP_RIGHT;
                            if (w_short) begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_shift <= w_shift_next;
                        end
                    end
                    ST_CAP_RIGHT: begin
                        if (w_boundary) begin
                            r_left_data    <= r_left_hold;
                            r_right_data   <= w_word;
                            r_sample_valid <= 1'b1;
                            r_cnt          <= '0;
                            r_shift        <= '0;
                            r_state        <= ST_CAP_LEFT;
                            if (w_short) begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_shift <= w_shift_next;
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_EDGE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb/tb_i2s_rx_deser.sv - self-checking bench for the I2S receiver
module tb_i2s_rx_deser;
    localparam int DW   = 16;
    localparam int HALF = 80;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          bclk_in = 1'b0;
    logic          lrck_in = 1'b0;
    logic          sdata_in = 1'b0;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        err;
        int          lat;
        logic        pv;
    } obs_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        err;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];

    logic prev_bit = 1'b0;
    int   bit_idx = 0;
    int   en_off_at = -1;
    int   en_on_at = -1;
    int   rst_at = -1;

    int   edge_cnt = 0;
    int   cap_edge = -100;
    logic b_prev = 1'b0;
    logic lr_at_rise = 1'b0;
    logic v_prev = 1'b0;

    i2s_rx_deser #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .bclk_in      (bclk_in),
        .lrck_in      (lrck_in),
        .sdata_in     (sdata_in),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #10 clk = ~clk;

    // Note the clk edge that first sees bclk high on each right-to-left boundary.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        b_prev   <= bclk_in;
        if (bclk_in && !b_prev) begin
            lr_at_rise <= lrck_in;
            if (!lrck_in && lr_at_rise) cap_edge <= edge_cnt + 1;
        end
    end

    // Record every valid cycle with its latency and whether the previous cycle was valid too.
    always @(negedge clk) begin
        if (sample_valid)
            obs_q.push_back('{l: left_data, r: right_data, err: frame_err,
                              lat: edge_cnt - cap_edge, pv: v_prev});
        v_prev <= sample_valid;
    end

    function automatic logic [63:0] align(input logic [63:0] p, input int n);
        return p << (64 - n);
    endfunction

    // First s slot bits, MSB first, truncated to 16 or zero-padded at the LSB end.
    function automatic logic [15:0] model_word(input logic [63:0] v, input int s);
        logic [63:0] m;
        m = v;
        for (int k = 0; k < 64 - s; k++) m[k] = 1'b0;
        return m[63:48];
    endfunction

    task automatic do_async_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({left_data, right_data, sample_valid, frame_err} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset_outputs got %h/%h v=%b e=%b want 0", left_data, right_data, sample_valid, frame_err);
        end
        #99;
        reset_n = 1'b1;
    endtask

    // One slot: lrck/data change while bclk is low, receiver samples on the rise.
    task automatic send_slot(input logic lr, input logic [63:0] v, input int s);
        for (int i = 0; i < s; i++) begin
            bclk_in = 1'b0;
            lrck_in = lr;
            if (i == 0) sdata_in = prev_bit;
            else        sdata_in = v[64 - i];
            if (bit_idx == en_off_at) en = 1'b0;
            if (bit_idx == en_on_at)  en = 1'b1;
            if (bit_idx == rst_at) begin
                fork
                    do_async_reset();
                join_none
            end
            #HALF;
            bclk_in = 1'b1;
            #HALF;
            bit_idx++;
        end
        prev_bit = v[64 - s];
    endtask

    task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int s, input logic expect_out,
                              inout logic err_acc);
        send_slot(1'b0, l, s);
        send_slot(1'b1, r, s);
        if (expect_out) begin
            err_acc = err_acc | (s < 16);
            exp_q.push_back('{l: model_word(l, s), r: model_word(r, s), err: err_acc});
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        en = 1'b0;
        en_off_at = -1;
        en_on_at = -1;
        rst_at = -1;
        #100;
        reset_n = 1'b1;
        #40;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic flush();
        send_slot(1'b0, 64'd0, 32);
        bclk_in = 1'b0;
        #200;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({left_data, right_data, sample_valid, frame_err} !== 34'd0) begin
            errors++;
            $display("FAIL reset_held got %h/%h v=%b e=%b want 0", left_data, right_data, sample_valid, frame_err);
        end
        #100;
        reset_n = 1'b1;
        #200;
        checks++;
        if ({left_data, right_data, sample_valid, frame_err} !== 34'd0) begin
            errors++;
            $display("FAIL reset_released got %h/%h v=%b e=%b want 0", left_data, right_data, sample_valid, frame_err);
        end
    endtask

    task automatic test_basic();
        logic ea;
        int   s;
        ea = 1'b0;
        apply_reset();
        en = 1'b1;
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        send_frame(align(64'h1234, 16), align(64'hABCD, 16), 32, 1'b1, ea);
        send_frame(align(64'h8000, 16), align(64'h7FFF, 16), 32, 1'b1, ea);
        for (int f = 0; f < 4; f++) begin
            s = 16 + 8 * int'($urandom_range(0, 2));
            send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, s, 1'b1, ea);
        end
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks += 3;
            if ({obs_q[i].l, obs_q[i].r} !== {exp_q[i].l, exp_q[i].r}) begin
                errors++;
                $display("FAIL basic_data[%0d] got %h/%h want %h/%h", i, obs_q[i].l, obs_q[i].r, exp_q[i].l, exp_q[i].r);
            end
            if (obs_q[i].err !== exp_q[i].err) begin
                errors++;
                $display("FAIL basic_err[%0d] got %b want %b", i, obs_q[i].err, exp_q[i].err);
            end
            if (obs_q[i].lat != 2 || obs_q[i].pv !== 1'b0) begin
                errors++;
                $display("FAIL basic_timing[%0d] got lat %0d prev %b want lat 2 prev 0", i, obs_q[i].lat, obs_q[i].pv);
            end
        end
    endtask

    task automatic test_truncate();
        logic ea;
        ea = 1'b0;
        apply_reset();
        en = 1'b1;
        send_frame(align(64'h111111, 24), align(64'h222222, 24), 32, 1'b0, ea);
        send_frame(align(64'hA5A5A5, 24), align(64'h0F0F0F, 24), 32, 1'b1, ea);
        flush();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL trunc_count got %0d want 1", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if ({obs_q[i].l, obs_q[i].r, obs_q[i].err} !== {16'hA5A5, 16'h0F0F, 1'b0}) begin
                errors++;
                $display("FAIL trunc_data got %h/%h e=%b want a5a5/0f0f e=0", obs_q[i].l, obs_q[i].r, obs_q[i].err);
            end
        end
    endtask

    task automatic test_short();
        logic ea;
        ea = 1'b0;
        apply_reset();
        en = 1'b1;
        send_frame(align(64'h55, 8), align(64'hAA, 8), 8, 1'b0, ea);
        send_frame(align(64'h81, 8), align(64'h7E, 8), 8, 1'b1, ea);
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b1, ea);
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL short_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ({obs_q[i].l, obs_q[i].r, obs_q[i].err} !== {exp_q[i].l, exp_q[i].r, exp_q[i].err}) begin
                errors++;
                $display("FAIL short_data[%0d] got %h/%h e=%b want %h/%h e=%b", i, obs_q[i].l, obs_q[i].r,
                         obs_q[i].err, exp_q[i].l, exp_q[i].r, exp_q[i].err);
            end
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL short_sticky got %b want 1", frame_err);
        end
        en = 1'b0;
        #100;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL short_en_clear got %b want 0", frame_err);
        end
    endtask

    task automatic test_enable();
        logic        ea;
        int          b0;
        logic [63:0] l2, r2;
        ea = 1'b0;
        apply_reset();
        en = 1'b1;
        l2 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b1, ea);
        send_frame(l2, r2, 32, 1'b1, ea);
        b0 = bit_idx;
        en_off_at = b0 + 42;
        en_on_at  = b0 + 3 * 64 + 42;
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        checks++;
        if ({left_data, right_data} !== {model_word(l2, 32), model_word(r2, 32)}) begin
            errors++;
            $display("FAIL en_hold got %h/%h want %h/%h", left_data, right_data, model_word(l2, 32), model_word(r2, 32));
        end
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b1, ea);
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL en_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ({obs_q[i].l, obs_q[i].r, obs_q[i].err} !== {exp_q[i].l, exp_q[i].r, exp_q[i].err}) begin
                errors++;
                $display("FAIL en_data[%0d] got %h/%h e=%b want %h/%h e=%b", i, obs_q[i].l, obs_q[i].r,
                         obs_q[i].err, exp_q[i].l, exp_q[i].r, exp_q[i].err);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ea;
        ea = 1'b0;
        apply_reset();
        en = 1'b1;
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        send_frame(align(64'hC3A5, 16), align(64'h5A3C, 16), 32, 1'b1, ea);
        rst_at = bit_idx + 10;
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b0, ea);
        send_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 32, 1'b1, ea);
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if ({obs_q[i].l, obs_q[i].r, obs_q[i].err} !== {exp_q[i].l, exp_q[i].r, exp_q[i].err}) begin
                errors++;
                $display("FAIL rstmid_data[%0d] got %h/%h e=%b want %h/%h e=%b", i, obs_q[i].l, obs_q[i].r,
                         obs_q[i].err, exp_q[i].l, exp_q[i].r, exp_q[i].err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_short();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
